// File: rtl/mac_result_capture_if.sv
// mac_result_capture_if
//   Groups every non-clock signal of mac_result_capture into one bundle.
//   slave  : the capture block. It receives the MAC stream, the clear and
//            rd_ready, and it drives the read port and the status outputs.
//   master : the environment, which is the MAC plus the downstream reader.
//   Signals:
//     mac_valid/mac_f  MAC result stream; mac_f is only meaningful when
//                      mac_valid is high.
//     clear            synchronous flush of the FIFO and all counters.
//     rd_data/rd_valid/rd_ready
//                      first-word-fall-through read handshake.
//     count/full/empty FIFO occupancy.
//     drop_cnt/cap_cnt/overflow
//                      stream statistics.
interface mac_result_capture_if #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  mac_valid;
  logic [DATA_WIDTH-1:0] mac_f;
  logic                  clear;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic [CNT_WIDTH-1:0]  drop_cnt;
  logic [CNT_WIDTH-1:0]  cap_cnt;
  logic                  overflow;

  modport master (
    output mac_valid, mac_f, clear, rd_ready,
    input  rd_data, rd_valid, count, full, empty, drop_cnt, cap_cnt, overflow
  );

  modport slave (
    input  mac_valid, mac_f, clear, rd_ready,
    output rd_data, rd_valid, count, full, empty, drop_cnt, cap_cnt, overflow
  );
endinterface

// File: rtl/mac_result_capture.sv
// mac_result_capture
//   Consumer-side endpoint for the MAC output stream. Every cycle with
//   mac_valid high, mac_f is pushed into a small FIFO. The FIFO is read out
//   through a first-word-fall-through ready/valid port. The block also keeps
//   a saturating count of samples dropped because the FIFO was full, a
//   saturating count of samples captured, and a sticky overflow flag.
//   Ports:
//     clk    rising-edge clock for all state.
//     reset  asynchronous, active-high. Clears every piece of state at once.
//     bus    mac_result_capture_if.slave. It carries the MAC input, clear,
//            the read handshake and the status outputs.
module mac_result_capture #(
  parameter int DATA_WIDTH = 20,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset,
  mac_result_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0]        PTR_ONE   = AW'(1);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]        DEPTH_CNT = CW'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] STAT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] STAT_MAX  = '1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]  cap_cnt_q, cap_cnt_d;
  logic                  overflow_q, overflow_d;

  logic is_full;
  logic is_empty;
  logic pop;
  logic push;
  logic drop;

  // A pop at the same edge frees a slot, so a full FIFO can still accept
  // the incoming sample. A sample is dropped only when it has nowhere to go.
  assign is_full  = (count_q == DEPTH_CNT);
  assign is_empty = (count_q == '0);
  assign pop      = !is_empty && bus.rd_ready;
  assign push     = bus.mac_valid && (!is_full || pop);
  assign drop     = bus.mac_valid && is_full && !pop;

  // The head entry falls straight through from storage. It is forced to
  // zero while empty so that stale memory contents are never visible after
  // a reset or a clear.
  assign bus.rd_data  = is_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.rd_valid = !is_empty;
  assign bus.count    = count_q;
  assign bus.full     = is_full;
  assign bus.empty    = is_empty;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.cap_cnt  = cap_cnt_q;
  assign bus.overflow = overflow_q;

  // Next-state logic. Clear has priority over everything, so a sample
  // arriving at the same edge is discarded and not counted. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    overflow_d = overflow_q;

    if (bus.clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = '0;
      cap_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.mac_f;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
        if (cap_cnt_q != STAT_MAX) begin
          cap_cnt_d = cap_cnt_q + STAT_ONE;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != STAT_MAX) begin
          drop_cnt_d = drop_cnt_q + STAT_ONE;
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and statistics state. The asynchronous reset returns the block
  // to empty at once, even mid-stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      cap_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset. An entry is only observable after it has been
  // written, because rd_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: doc/mac_result_capture.md
Name: mac_result_capture

Overview:
- Consumer-side endpoint for the part3_mac output interface.
- Samples `f` on every cycle where `valid_out` is high and stores it in a small FIFO.
- Presents stored results to a downstream reader over a ready/valid handshake.
- Tracks samples dropped while full, and the total number captured, so the MAC stream can be drained and checked by a slower consumer.

Parameters:
- DATA_WIDTH, 20, width of captured MAC result (signed, matches MAC `f`).
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 16, width of drop and capture counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- mac_valid  in  1  driven from MAC `valid_out`.
- mac_f  in  DATA_WIDTH  driven from MAC `f` (signed); meaningful only when mac_valid=1.
- clear  in  1  synchronous flush of FIFO and counters.
- rd_data  out  DATA_WIDTH  head-of-FIFO result.
- rd_valid  out  1  rd_data holds a valid entry.
- rd_ready  in  1  reader accepts rd_data this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- drop_cnt  out  CNT_WIDTH  samples lost because FIFO was full.
- cap_cnt  out  CNT_WIDTH  samples successfully written.
- overflow  out  1  sticky; set on first drop.

Behaviour:
- **Reset.** Asserting reset, at any time and mid-stream, immediately forces:
  - rd_valid=0, rd_data=0, count=0, empty=1, full=0;
  - drop_cnt=0, cap_cnt=0, overflow=0;
  - read/write pointers=0.
- **Write.** At a rising edge with mac_valid=1 and no clear, mac_f is written at the write pointer if the FIFO is not full. Otherwise it is dropped.
  - Write pointer wraps DEPTH-1 -> 0.
- **Read.** A pop occurs at a rising edge where rd_valid=1 and rd_ready=1. The read pointer advances, wrapping DEPTH-1 -> 0.
- **Output mode.** First-word-fall-through.
  - rd_data = entry at read pointer.
  - rd_valid = !empty.
  - Both are combinational from registered state, with no extra pipeline stage.
- **Latency.** A sample written at edge t is visible on rd_data/rd_valid in the cycle after edge t, i.e. 1 cycle from mac_valid.
- **Handshake.**
  - rd_data stays stable while rd_valid=1 and rd_ready=0.
  - rd_ready while empty has no effect.
- **Full with simultaneous pop.** If full, mac_valid=1 and a pop both occur at the same edge, the write is accepted. count stays DEPTH; no drop.
- **Empty with simultaneous write.** If empty, a write occurs and rd_ready=1 at the same edge, no pop happens (rd_valid was 0). count becomes 1.
- **Count update.** count increments on write-only, decrements on pop-only, and is unchanged when both or neither occur.
- **Drops.** A drop increments drop_cnt and sets overflow.
- **Capture count.** Each accepted write increments cap_cnt.
- **Counter saturation.** Both counters saturate at all-ones; no wrap.
- **Clear.**
  - clear=1 at an edge resets pointers, count, counters and overflow, exactly like reset but synchronously.
  - clear takes priority over a simultaneous write and pop; that sample is discarded and not counted.
- **Data handling.** mac_f is stored bit-exact: no sign extension, rounding or truncation.
- **Idle input.** When mac_valid=0, mac_f is ignored, even if X.

Test Plan:
- **Reset then single capture.** Reset 2 cycles, then mac_valid=1, mac_f=-5 (20'hFFFFB) for 1 cycle, rd_ready=0.
  - Next cycle: rd_valid=1, rd_data=20'hFFFFB, count=1, cap_cnt=1.
- **Ordered drain.** Capture 3 values 100, -200, 524287 back-to-back, then rd_ready=1 for 3 cycles.
  - rd_data emits 100, -200, 524287 in order.
  - empty=1 after the third pop.
- **Overflow.** DEPTH=8, rd_ready=0, mac_valid=1 for 10 cycles with values 1..10.
  - full=1, count=8, drop_cnt=2, overflow=1.
  - Draining yields 1..8.
- **Full plus simultaneous pop.** With the FIFO full of 1..8, one cycle of mac_valid=1 (mac_f=99) and rd_ready=1.
  - Pop returns 1, count stays 8, drop_cnt unchanged.
  - The last entry drained is 99.
- **Mid-stream async reset.** Assert reset between clock edges while count=5.
  - rd_valid=0, count=0 and counters=0 before the next edge.
  - After release, the next capture of 7 appears as the head.
- **Clear priority.** clear=1, mac_valid=1 (mac_f=42) and rd_ready=1 in the same cycle with count=3.
  - Next cycle: count=0, empty=1, cap_cnt=0; 42 is not stored.
